// File: rtl/mux_stream_nto1.sv
// mux_stream_nto1: N-to-1 stream multiplexer with a registered one-entry output.
//
// Several producers, each with its own valid/ready handshake, share one consumer.
// A combinational arbiter picks at most one channel per cycle. The chosen word is
// captured into the output register on the next rising edge.
//
// Arbitration modes (MODE):
//   0  round-robin. The search starts at rr_ptr, and the pointer moves past each winner.
//   1  fixed priority. The lowest valid index wins.
//   2  external select. The sel input chooses the channel. An out-of-range or idle
//      channel grants nothing.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_data    CHANNELS*WIDTH packed words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (only the granted channel can see 1)
//   sel        granted channel index in MODE 2
//   out_data   registered word
//   out_chan   channel index that supplied out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts the held word

module mux_stream_nto1 #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    localparam int SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    typedef enum logic {
        ST_EMPTY,
        ST_FULL
    } state_t;

    state_t           state, state_next;
    logic [SEL_W-1:0] rr_ptr, rr_ptr_next;
    logic [SEL_W:0]   rr_sum;
    logic             can_load;
    logic             grant_any;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_word;
    logic             accept;

    assign out_valid = (state == ST_FULL);
    // The slot is free if it is empty or if the held word leaves this cycle.
    assign can_load  = ~out_valid | out_ready;

    // Arbiter
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        rr_sum    = '0;
        case (MODE)
            0: begin
                // Visit channels in the order rr_ptr, rr_ptr+1, ... with modulo-CHANNELS
                // wrap. CHANNELS need not be a power of two, so the wrap is explicit.
                for (int k = 0; k < CHANNELS; k++) begin
                    rr_sum = {1'b0, rr_ptr} + (SEL_W+1)'(k);
                    if (rr_sum >= (SEL_W+1)'(CHANNELS)) begin
                        rr_sum = rr_sum - (SEL_W+1)'(CHANNELS);
                    end
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (!grant_any && in_valid[i] && rr_sum == (SEL_W+1)'(i)) begin
                            grant_any = 1'b1;
                            grant_idx = SEL_W'(i);
                        end
                    end
                end
            end
            1: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (!grant_any && in_valid[i]) begin
                        grant_any = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
            end
            default: begin
                // A sel at or above CHANNELS matches no channel and grants nothing.
                for (int i = 0; i < CHANNELS; i++) begin
                    if (in_valid[i] && sel == SEL_W'(i)) begin
                        grant_any = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
            end
        endcase
    end

    // The winner is always valid, so accept needs only the load and reset qualifiers.
    assign accept = grant_any & can_load & rst_n;

    always_comb begin
        in_ready   = '0;
        grant_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                in_ready[i] = accept;
                grant_word  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage next state
    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        unique case (state)
            ST_EMPTY: if (accept) state_next = ST_FULL;
            ST_FULL:  if (out_ready && !accept) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
        if (MODE == 0 && accept) begin
            rr_ptr_next = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            rr_ptr   <= '0;
            out_data <= '0;
            out_chan <= '0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
            if (accept) begin
                out_data <= grant_word;
                out_chan <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_mux_stream_nto1.sv
// tb_mux_stream_nto1: checks three instances of the multiplexer.
// Instance u0 uses MODE 0 with 4 channels, u1 uses MODE 1 with 4 channels,
// and u2 uses MODE 2 with 3 channels.
module tb_mux_stream_nto1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] d0, d1;
    logic [23:0] d2;
    logic [3:0]  v0, v1, r0, r1;
    logic [2:0]  v2, r2;
    logic [1:0]  s0, s1, s2, oc0, oc1, oc2;
    logic [7:0]  od0, od1, od2;
    logic        ov0, ov1, ov2, or0, or1, or2;

    mux_stream_nto1 #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(v0), .in_ready(r0), .sel(s0),
        .out_data(od0), .out_chan(oc0), .out_valid(ov0), .out_ready(or0));
    mux_stream_nto1 #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1), .in_ready(r1), .sel(s1),
        .out_data(od1), .out_chan(oc1), .out_valid(ov1), .out_ready(or1));
    mux_stream_nto1 #(.WIDTH(8), .CHANNELS(3), .MODE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(v2), .in_ready(r2), .sel(s2),
        .out_data(od2), .out_chan(oc2), .out_valid(ov2), .out_ready(or2));

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic idle_all();
        v0 = '0; v1 = '0; v2 = '0;
        s0 = '0; s1 = '0; s2 = '0;
        or0 = 1'b1; or1 = 1'b1; or2 = 1'b1;
        d0 = 32'h13121110; d1 = 32'h13121110; d2 = 24'h121110;
    endtask

    // Reference arbiter. It lists the channels in the order the mode tries them,
    // then takes the first valid channel in that list.
    function automatic int pick(input int mode, input int nch, input int ptr,
                                input logic [3:0] valid, input int sel);
        int order[$];
        int res;
        res = -1;
        if (mode == 0) begin
            for (int k = 0; k < nch; k++) order.push_back((ptr + k) % nch);
        end else if (mode == 1) begin
            for (int k = 0; k < nch; k++) order.push_back(k);
        end else if (sel < nch) begin
            order.push_back(sel);
        end
        foreach (order[j]) begin
            if (res < 0 && valid[order[j]]) res = order[j];
        end
        return res;
    endfunction

    typedef struct {
        logic        rst;
        logic [31:0] data;
        logic [3:0]  valid;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic        cd;
        logic [1:0]  chan;
        logic [7:0]  word;
    } vec_t;

    vec_t tbl[16];

    // Reference model state, indexed by instance.
    logic       m_ov[3];
    logic [7:0] m_data[3];
    int         m_chan[3];
    int         m_ptr[3];

    initial begin
        logic [31:0] rd;
        logic [3:0]  rv;
        logic [1:0]  rs;
        logic        ro[3];
        logic        rst;
        int          g[3];
        logic        acc[3];
        logic [3:0]  ar;
        logic        ao;
        logic [1:0]  ac;
        logic [7:0]  ad;
        int          nch;

        // MODE 0 vectors: rotation, wrap/skip, backpressure, drain, reset.
        tbl[0]  = '{1'b1, 32'h13121110, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h10};
        tbl[1]  = '{1'b1, 32'h13121110, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'h11};
        tbl[2]  = '{1'b1, 32'h13121110, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h12};
        tbl[3]  = '{1'b1, 32'h13121110, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3, 8'h13};
        tbl[4]  = '{1'b1, 32'h13121110, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h10};
        tbl[5]  = '{1'b1, 32'h13121110, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h12};
        tbl[6]  = '{1'b1, 32'h1312A510, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'hA5};
        tbl[7]  = '{1'b1, 32'h13121110, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h12};
        tbl[8]  = '{1'b1, 32'h135C1110, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 8'h12};
        tbl[9]  = '{1'b1, 32'h135C1110, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 8'h12};
        tbl[10] = '{1'b1, 32'h135C1110, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 8'h5C};
        tbl[11] = '{1'b1, 32'h13121110, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
        tbl[12] = '{1'b1, 32'h13121110, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0, 8'h10};
        tbl[13] = '{1'b1, 32'h13121110, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'h11};
        tbl[14] = '{1'b0, 32'h13121110, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0, 8'h00};
        tbl[15] = '{1'b1, 32'h13121110, 4'b1010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 8'h11};

        idle_all();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);

        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            rst_n = tbl[n].rst;
            d0    = tbl[n].data;
            v0    = tbl[n].valid;
            or0   = tbl[n].ordy;
            #1;
            chk($sformatf("tbl%0d_in_ready", n), {28'd0, r0}, {28'd0, tbl[n].rdy});
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_out_valid", n), {31'd0, ov0}, {31'd0, tbl[n].ov});
            if (tbl[n].cd) begin
                chk($sformatf("tbl%0d_out_chan", n), {30'd0, oc0}, {30'd0, tbl[n].chan});
                chk($sformatf("tbl%0d_out_data", n), {24'd0, od0}, {24'd0, tbl[n].word});
            end
        end

        // MODE 1: ch1 beats ch3 until ch1 drops valid.
        @(negedge clk);
        idle_all();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            v1 = (n < 3) ? 4'b1010 : 4'b1000;
            #1;
            chk("prio_in_ready", {28'd0, r1}, (n < 3) ? 32'h2 : 32'h8);
            @(posedge clk);
            #1;
            chk("prio_out_chan", {30'd0, oc1}, (n < 3) ? 32'd1 : 32'd3);
            chk("prio_out_data", {24'd0, od1}, (n < 3) ? 32'h11 : 32'h13);
        end

        // MODE 2: sel=1 accepts. sel=3 is out of range. sel=2 with ch2 idle grants nothing.
        @(negedge clk);
        v1 = '0;
        v2 = 3'b010;
        s2 = 2'd1;
        #1;
        chk("ext_sel1_in_ready", {29'd0, r2}, 32'h2);
        @(posedge clk);
        #1;
        chk("ext_sel1_out_valid", {31'd0, ov2}, 32'd1);
        chk("ext_sel1_out_chan", {30'd0, oc2}, 32'd1);
        chk("ext_sel1_out_data", {24'd0, od2}, 32'h11);
        @(negedge clk);
        v2 = 3'b111;
        s2 = 2'd3;
        #1;
        chk("ext_sel3_in_ready", {29'd0, r2}, 32'h0);
        @(posedge clk);
        #1;
        chk("ext_sel3_out_valid", {31'd0, ov2}, 32'd0);
        @(negedge clk);
        v2 = 3'b011;
        s2 = 2'd2;
        #1;
        chk("ext_sel2_idle_in_ready", {29'd0, r2}, 32'h0);

        // Randomized run of all three instances against the reference model.
        @(negedge clk);
        idle_all();
        rst_n = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            m_ov[k] = 1'b0; m_data[k] = 8'h00; m_chan[k] = 0; m_ptr[k] = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 49) != 0);
            rd  = $urandom;
            rv  = 4'($urandom_range(0, 15));
            rs  = 2'($urandom_range(0, 3));
            for (int k = 0; k < 3; k++) ro[k] = ($urandom_range(0, 3) != 0);
            rst_n = rst;
            d0 = rd; d1 = rd; d2 = rd[23:0];
            v0 = rv; v1 = rv; v2 = rv[2:0];
            s0 = rs; s1 = rs; s2 = rs;
            or0 = ro[0]; or1 = ro[1]; or2 = ro[2];
            #1;
            for (int k = 0; k < 3; k++) begin
                nch    = (k == 2) ? 3 : 4;
                g[k]   = pick(k, nch, m_ptr[k], (k == 2) ? {1'b0, rv[2:0]} : rv, int'(rs));
                acc[k] = rst && g[k] >= 0 && (!m_ov[k] || ro[k]);
                case (k)
                    0:       begin ar = r0;          ao = ov0; ac = oc0; ad = od0; end
                    1:       begin ar = r1;          ao = ov1; ac = oc1; ad = od1; end
                    default: begin ar = {1'b0, r2};  ao = ov2; ac = oc2; ad = od2; end
                endcase
                chk($sformatf("rnd%0d_u%0d_in_ready", cyc, k), {28'd0, ar},
                    acc[k] ? (32'd1 << g[k]) : 32'd0);
                chk($sformatf("rnd%0d_u%0d_out_valid", cyc, k), {31'd0, ao}, {31'd0, m_ov[k]});
                if (m_ov[k]) begin
                    chk($sformatf("rnd%0d_u%0d_out_chan", cyc, k), {30'd0, ac}, m_chan[k]);
                    chk($sformatf("rnd%0d_u%0d_out_data", cyc, k), {24'd0, ad},
                        {24'd0, m_data[k]});
                end
            end
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                nch = (k == 2) ? 3 : 4;
                if (!rst) begin
                    m_ov[k] = 1'b0; m_data[k] = 8'h00; m_chan[k] = 0; m_ptr[k] = 0;
                end else if (acc[k]) begin
                    m_ov[k]   = 1'b1;
                    m_data[k] = rd[g[k]*8 +: 8];
                    m_chan[k] = g[k];
                    if (k == 0) m_ptr[k] = (g[k] + 1) % nch;
                end else if (ro[k]) begin
                    m_ov[k] = 1'b0;
                end
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
